// File: rtl/matmul_bias_act.sv
// Linear-layer epilogue: buffers an unordered C element stream, adds per-column bias,
// applies optional ReLU with saturation and re-emits row-major over valid/ready.
module matmul_bias_act #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 2,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic [$clog2(M)-1:0]  c_row,
    input  logic [$clog2(N)-1:0]  c_col,
    input  logic                  c_valid,
    input  logic                  c_done,
    input  logic [DATA_WIDTH-1:0] bias_data,
    input  logic [$clog2(N)-1:0]  bias_idx,
    input  logic                  bias_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [$clog2(M)-1:0]  out_row,
    output logic [$clog2(N)-1:0]  out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  err
);
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_FIN     = 2'd3
    } state_t;

    state_t                     r_state;
    logic [DATA_WIDTH-1:0]      r_buf  [M][N];
    logic [DATA_WIDTH-1:0]      r_bias [N];
    logic [M-1:0][N-1:0]        r_mask;

    logic                       w_c_in_range;
    logic                       w_b_in_range;
    logic                       w_wr_en;
    logic                       w_accept;
    logic                       w_last;
    logic [M-1:0][N-1:0]        w_mask_nxt;
    logic [RW-1:0]              w_sel_row;
    logic [CW-1:0]              w_sel_col;
    logic [DATA_WIDTH-1:0]      w_sel_c;
    logic [DATA_WIDTH-1:0]      w_sel_b;
    logic [DATA_WIDTH:0]        w_sum;
    logic [DATA_WIDTH-1:0]      w_result;

    function automatic logic [DATA_WIDTH-1:0] sat_act(input logic [DATA_WIDTH:0] sum);
        logic [DATA_WIDTH-1:0] v;
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            v = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            v = sum[DATA_WIDTH-1:0];
        end
        return ((RELU != 0) && v[DATA_WIDTH-1]) ? '0 : v;
    endfunction

    // Next element to present, forwarding same-cycle C and bias writes so the result is never stale.
    always_comb begin
        w_c_in_range = (32'(c_row) < M) && (32'(c_col) < N);
        w_b_in_range = (32'(bias_idx) < N);
        w_wr_en      = (r_state == S_COLLECT) && c_valid && !start && w_c_in_range;
        w_accept     = (r_state == S_EMIT) && out_valid && out_ready;
        w_last       = (32'(out_row) == M - 1) && (32'(out_col) == N - 1);
        w_mask_nxt   = r_mask;
        if (w_wr_en) begin
            w_mask_nxt[c_row][c_col] = 1'b1;
        end else begin
            w_mask_nxt = r_mask;
        end
        if (r_state == S_EMIT) begin
            if (32'(out_col) == N - 1) begin
                w_sel_row = out_row + ROW_ONE;
                w_sel_col = '0;
            end else begin
                w_sel_row = out_row;
                w_sel_col = out_col + COL_ONE;
            end
        end else begin
            w_sel_row = '0;
            w_sel_col = '0;
        end
        if (w_wr_en && (c_row == w_sel_row) && (c_col == w_sel_col)) begin
            w_sel_c = c_data;
        end else if (w_mask_nxt[w_sel_row][w_sel_col]) begin
            w_sel_c = r_buf[w_sel_row][w_sel_col];
        end else begin
            w_sel_c = '0;
        end
        if (bias_valid && w_b_in_range && (bias_idx == w_sel_col)) begin
            w_sel_b = bias_data;
        end else begin
            w_sel_b = r_bias[w_sel_col];
        end
        w_sum    = {w_sel_c[DATA_WIDTH-1], w_sel_c} + {w_sel_b[DATA_WIDTH-1], w_sel_b};
        w_result = sat_act(w_sum);
    end

    // Control FSM with registered stream outputs; start from any state restarts collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_state   <= S_COLLECT;
                r_mask    <= '0;
                out_valid <= 1'b0;
                err       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_COLLECT: begin
                        r_mask <= w_mask_nxt;
                        err    <= err | (c_valid && !w_c_in_range) | (c_done && !(&w_mask_nxt));
                        if (c_done) begin
                            r_state   <= S_EMIT;
                            out_valid <= 1'b1;
                            out_data  <= w_result;
                            out_row   <= '0;
                            out_col   <= '0;
                        end
                    end
                    S_EMIT: begin
                        if (w_accept) begin
                            if (w_last) begin
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                                r_state   <= S_FIN;
                            end else begin
                                out_data <= w_result;
                                out_row  <= w_sel_row;
                                out_col  <= w_sel_col;
                            end
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Bias table persists across runs and is writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bias_valid && w_b_in_range) begin
            r_bias[bias_idx] <= bias_data;
        end
    end

    // Element buffer needs no reset: the fill mask decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[c_row][c_col] <= c_data;
        end
    end
endmodule

// File: tb/tb_matmul_bias_act.sv
// Self-checking bench for matmul_bias_act: vector table, directed corner sequences
// and randomized runs against a plain-arithmetic reference model.
module tb_matmul_bias_act;
    localparam int M = 4;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] c_data = '0;
    logic [1:0]  c_row = '0;
    logic [0:0]  c_col = '0;
    logic        c_valid = 1'b0;
    logic        c_done = 1'b0;
    logic [15:0] bias_data = '0;
    logic [0:0]  bias_idx = '0;
    logic        bias_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [15:0] a_data, b_data;
    logic [1:0]  a_row, b_row;
    logic [0:0]  a_col, b_col;
    logic        a_valid, b_valid, a_done, b_done, a_err, b_err;

    matmul_bias_act #(.DATA_WIDTH(16), .FRAC_WIDTH(8), .M(M), .N(N), .RELU(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .c_data(c_data), .c_row(c_row), .c_col(c_col),
        .c_valid(c_valid), .c_done(c_done), .bias_data(bias_data), .bias_idx(bias_idx),
        .bias_valid(bias_valid), .out_data(a_data), .out_row(a_row), .out_col(a_col),
        .out_valid(a_valid), .out_ready(out_ready), .done(a_done), .err(a_err));

    matmul_bias_act #(.DATA_WIDTH(16), .FRAC_WIDTH(8), .M(M), .N(N), .RELU(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .c_data(c_data), .c_row(c_row), .c_col(c_col),
        .c_valid(c_valid), .c_done(c_done), .bias_data(bias_data), .bias_idx(bias_idx),
        .bias_valid(bias_valid), .out_data(b_data), .out_row(b_row), .out_col(b_col),
        .out_valid(b_valid), .out_ready(out_ready), .done(b_done), .err(b_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] b;
        logic [15:0] exp_relu;
        logic [15:0] exp_lin;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_c    [M][N];
    bit          m_p    [M][N];
    int          m_bias [N];
    logic [15:0] got_a  [M*N];
    logic [15:0] got_b  [M*N];
    vec_t        vt     [8];
    logic [15:0] t1_exp [M*N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer sum, clamp to 16-bit signed, then optional ReLU.
    function automatic logic [15:0] model(input int c, input int b, input bit relu);
        int s;
        s = c + b;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); c_done = 1'b1;
        @(posedge clk); #1; c_done = 1'b0;
    endtask

    task automatic send_c(input int r, input int c, input logic [15:0] d, input bit with_done);
        @(negedge clk);
        c_valid = 1'b1; c_row = 2'(r); c_col = 1'(c); c_data = d; c_done = with_done;
        @(posedge clk); #1;
        c_valid = 1'b0; c_done = 1'b0;
    endtask

    task automatic send_bias(input int i, input logic [15:0] v);
        @(negedge clk);
        bias_valid = 1'b1; bias_idx = 1'(i); bias_data = v;
        @(posedge clk); #1;
        bias_valid = 1'b0;
        m_bias[i] = sx(v);
    endtask

    task automatic set_t1();
        m_c[0][0] = 1024; m_c[0][1] = 1280; m_c[1][0] = 2560; m_c[1][1] = 2816;
        m_c[2][0] = 4096; m_c[2][1] = 4352; m_c[3][0] = 768;  m_c[3][1] = 512;
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) m_p[r][c] = 1'b1;
    endtask

    // mode 0: ready always, 1: random ready, 2: 3-cycle stall at beat 3, 3: bias write mid-stream
    task automatic collect(input int mode, input int abort_at, input bit exp_err);
        int beat, cyc, stall_cnt, r, c;
        bit stalled, rdy;
        logic [15:0] h_d;
        logic [1:0]  h_r;
        logic [0:0]  h_c;
        beat = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
        while (beat < M*N && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bias_valid = 1'b0;
            if (cyc == 1) chk("latency_valid", 32'(a_valid), 32'd1);
            if (stalled) begin
                chk("hold_valid", 32'(a_valid), 32'd1);
                chk("hold_data", 32'(a_data), 32'(h_d));
                chk("hold_row", 32'(a_row), 32'(h_r));
                chk("hold_col", 32'(a_col), 32'(h_c));
            end
            chk("no_early_done", 32'(a_done), 32'd0);
            case (mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    if (beat == 3 && stall_cnt < 3) begin rdy = 1'b0; stall_cnt++; end
                    else rdy = 1'b1;
                end
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (beat == abort_at && a_valid) begin
                start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
                @(negedge clk);
                out_ready = 1'b0;
                chk("abort_valid", 32'(a_valid), 32'd0);
                chk("abort_done", 32'(a_done), 32'd0);
                return;
            end
            if (a_valid) begin
                chk("valid_b", 32'(b_valid), 32'd1);
                if (rdy) begin
                    r = beat / N; c = beat % N;
                    chk("beat_row", 32'(a_row), 32'(r));
                    chk("beat_col", 32'(a_col), 32'(c));
                    chk("relu_data", 32'(a_data), 32'(model(m_p[r][c] ? m_c[r][c] : 0, m_bias[c], 1'b1)));
                    chk("lin_data", 32'(b_data), 32'(model(m_p[r][c] ? m_c[r][c] : 0, m_bias[c], 1'b0)));
                    got_a[beat] = a_data; got_b[beat] = b_data;
                    if (mode == 3 && beat == 1) begin
                        bias_valid = 1'b1; bias_idx = 1'b0; bias_data = 16'h0200;
                        m_bias[0] = 512;
                    end
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; h_d = a_data; h_r = a_row; h_c = a_col;
                end
            end else begin
                stalled = 1'b0;
            end
        end
        if (beat < M*N) chk("beat_timeout", 32'(beat), 32'(M*N));
        @(negedge clk);
        bias_valid = 1'b0;
        out_ready = 1'b0;
        chk("done_pulse", 32'(a_done), 32'd1);
        chk("done_pulse_b", 32'(b_done), 32'd1);
        chk("valid_drop", 32'(a_valid), 32'd0);
        chk("err", 32'(a_err), 32'(exp_err));
        chk("err_b", 32'(b_err), 32'(exp_err));
        @(negedge clk);
        chk("done_once", 32'(a_done), 32'd0);
    endtask

    task automatic run(input bit do_start, input int mode, input int abort_at, input bit merge_done);
        int order[$];
        int tmp, j;
        bit miss;
        if (do_start) pulse_start();
        miss = 1'b0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (m_p[r][c]) order.push_back(r*N + c); else miss = 1'b1;
        for (int i = order.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        if (order.size() > 0) send_c(order[0] / N, order[0] % N, 16'($urandom), 1'b0);
        for (int i = 0; i < order.size(); i++)
            send_c(order[i] / N, order[i] % N, 16'(m_c[order[i] / N][order[i] % N]),
                   merge_done && (i == order.size() - 1));
        if (!merge_done || order.size() == 0) pulse_done();
        collect(mode, abort_at, miss);
    endtask

    initial begin
        vt[0] = '{16'h0400, 16'hFB80, 16'h0000, 16'hFF80};
        vt[1] = '{16'h7F80, 16'h0100, 16'h7FFF, 16'h7FFF};
        vt[2] = '{16'h8000, 16'hFF00, 16'h0000, 16'h8000};
        vt[3] = '{16'h0500, 16'h0100, 16'h0600, 16'h0600};
        vt[4] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        vt[5] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        vt[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000};
        vt[7] = '{16'h4000, 16'h4000, 16'h7FFF, 16'h7FFF};
        t1_exp = '{16'h0000, 16'h0600, 16'h0580, 16'h0C00, 16'h0B80, 16'h1200, 16'h0000, 16'h0300};
        for (int i = 0; i < N; i++) m_bias[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_rowcol", 32'({a_row, a_col}), 32'd0);
        rst_n = 1'b1;

        // T1 basic, last element merged with c_done
        set_t1();
        send_bias(0, 16'hFB80);
        send_bias(1, 16'h0100);
        run(1'b1, 0, -1, 1'b1);
        for (int i = 0; i < M*N; i++) chk("t1_beat", 32'(got_a[i]), 32'(t1_exp[i]));

        // Arithmetic vector table on element (0,0)
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) begin m_c[r][c] = 0; m_p[r][c] = 1'b1; end
            m_c[0][0] = sx(vt[v].c);
            send_bias(0, vt[v].b);
            send_bias(1, 16'h0000);
            run(1'b1, v % 2, -1, v[0]);
            chk("vec_relu", 32'(got_a[0]), 32'(vt[v].exp_relu));
            chk("vec_lin", 32'(got_b[0]), 32'(vt[v].exp_lin));
        end

        // T3 backpressure, then bias write mid-stream
        set_t1();
        send_bias(0, 16'hFB80);
        send_bias(1, 16'h0100);
        run(1'b1, 2, -1, 1'b0);
        for (int i = 0; i < M*N; i++) chk("t3_beat", 32'(got_a[i]), 32'(t1_exp[i]));
        run(1'b1, 3, -1, 1'b0);
        chk("bias_mid_old", 32'(got_a[0]), 32'h0000);
        chk("bias_mid_new", 32'(got_a[2]), 32'h0C00);

        // T4 missing element (2,1)
        send_bias(0, 16'hFB80);
        set_t1();
        m_p[2][1] = 1'b0;
        run(1'b1, 0, -1, 1'b0);
        chk("missing_elem", 32'(got_a[5]), 32'h0100);

        // T5 abort at beat 3, then clean run without another start
        set_t1();
        run(1'b1, 0, 3, 1'b0);
        run(1'b0, 0, -1, 1'b0);
        for (int i = 0; i < M*N; i++) chk("t5_beat", 32'(got_a[i]), 32'(t1_exp[i]));

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) begin
                m_c[r][c] = sx(16'($urandom));
                m_p[r][c] = ($urandom_range(0, 7) != 0);
            end
            send_bias(0, 16'($urandom));
            send_bias(1, 16'($urandom));
            run(1'b1, 1, -1, k[0]);
        end

        // T6 reset mid-collect clears outputs and bias
        set_t1();
        pulse_start();
        send_c(1, 0, 16'h1234, 1'b0);
        send_c(3, 1, 16'h0042, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst6_data", 32'(a_data), 32'd0);
        chk("rst6_valid", 32'(a_valid | b_valid), 32'd0);
        chk("rst6_err", 32'(a_err | b_err), 32'd0);
        chk("rst6_done", 32'(a_done | b_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m_bias[i] = 0;
        run(1'b1, 0, -1, 1'b0);
        chk("rst6_bias_zero", 32'(got_a[0]), 32'h0400);
        send_bias(0, 16'hFB80);
        send_bias(1, 16'h0100);
        run(1'b1, 1, -1, 1'b0);
        for (int i = 0; i < M*N; i++) chk("t6_beat", 32'(got_a[i]), 32'(t1_exp[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
